// File: rtl/instr_queue_if.sv
// Handshake bundle between the instruction fetch side, the prefetch queue and
// the control FSM that consumes decoded opcode/operand fields.
interface instr_queue_if #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 16,
  parameter int DEPTH     = 4
);
  localparam int IW = OPCODE_W + OPERAND_W;
  localparam int CW = $clog2(DEPTH + 1);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [IW-1:0]        in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;
  logic [CW-1:0]        count;

  // Fetch/consumer side drives the requests, the queue answers.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, opcode, operand, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, opcode, operand, count
  );
endinterface

// File: rtl/instr_queue.sv
// Stallable, flushable instruction prefetch queue: circular buffer of DEPTH
// words, oldest word presented split into opcode/operand (NOP when empty).
module instr_queue #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 16,
  parameter int DEPTH     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_queue_if.slave  bus
);
  localparam int IW = OPCODE_W + OPERAND_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  // Ready/valid depend only on the occupancy register, never on out_ready.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.out_ready & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Only the slot under wr_ptr changes; flushed pushes leave storage alone.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign mem_d[gi] = (push && !bus.flush && (wr_ptr_q == PW'(gi)))
                       ? bus.in_data : mem_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry contents carry no reset; they are only observed while counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.count     = count_q;
  assign bus.opcode    = empty ? '0 : head[IW-1:OPERAND_W];
  assign bus.operand   = empty ? '0 : head[OPERAND_W-1:0];
endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed test-plan sequences followed by
// random traffic, checked against a plain queue model every cycle.
module tb_instr_queue;
  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 16;
  localparam int DEPTH     = 4;
  localparam int IW        = OPCODE_W + OPERAND_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_queue_if #(.OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W), .DEPTH(DEPTH)) bus ();

  instr_queue #(.OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit edge_seen = 1'b0;
  logic [IW-1:0] exp_q[$];

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cycle, got, exp);
    end
  endtask

  // Reference: bounded FIFO of accepted words; flush/reset empty it.
  always @(posedge clk) begin
    int sz;
    bit acc;
    bit tak;
    sz  = exp_q.size();
    acc = bus.in_valid && (sz < DEPTH);
    tak = bus.out_ready && (sz > 0);
    if (!rst_n || bus.flush) begin
      exp_q.delete();
    end else begin
      if (tak) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(bus.in_data);
    end
    edge_seen <= 1'b1;
    cycle++;
  end

  // Monitor: compares the DUT outputs against the model between edges.
  always @(negedge clk) begin
    if (edge_seen) begin
      logic [IW-1:0] head_exp;
      head_exp = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("count", bus.count, exp_q.size());
      chk("in_ready", bus.in_ready, exp_q.size() < DEPTH);
      chk("out_valid", bus.out_valid, exp_q.size() > 0);
      chk("opcode", bus.opcode, head_exp[IW-1:OPERAND_W]);
      chk("operand", bus.operand, head_exp[OPERAND_W-1:0]);
    end
  end

  task automatic cyc(bit v, logic [IW-1:0] d, bit r, bit f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word through an empty queue.
    cyc(1, 20'hA1234, 0, 0);
    cyc(0, 20'h0, 0, 0);
    cyc(0, 20'h0, 1, 0);
    cyc(0, 20'h0, 0, 0);

    // Fill to full, hold a fifth word, then drain.
    for (int i = 1; i <= 4; i++) cyc(1, IW'((i << 16) | i), 0, 0);
    cyc(1, 20'h50005, 0, 0);
    cyc(1, 20'h50005, 1, 0);
    cyc(1, 20'h50005, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 20'h0, 1, 0);

    // Streaming across pointer wrap.
    cyc(1, 20'hFFFFF, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, IW'(i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 20'h0, 1, 0);

    // Flush with a simultaneous push and pop.
    for (int i = 0; i < 3; i++) cyc(1, IW'(20'h30000 + i), 0, 0);
    cyc(1, 20'h77777, 1, 1);
    cyc(1, 20'hF00FF, 0, 0);
    cyc(0, 20'h0, 1, 0);
    cyc(0, 20'h0, 0, 0);

    // Reset in the middle of operation.
    cyc(1, 20'h11111, 0, 0);
    cyc(1, 20'h22222, 0, 0);
    rst_n = 1'b0;
    cyc(1, 20'h33333, 1, 0);
    rst_n = 1'b1;
    cyc(1, 20'h44444, 0, 0);
    cyc(0, 20'h0, 1, 0);

    // Pop while full does not admit a same-cycle push.
    for (int i = 0; i < 4; i++) cyc(1, IW'(20'h60000 + i), 0, 0);
    cyc(1, 20'h6AAAA, 1, 0);
    cyc(1, 20'h6AAAA, 0, 0);
    cyc(0, 20'h0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 20'h0, 1, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cyc(($urandom_range(0, 3) != 0), IW'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(0, 20'h0, 1, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Parametrised instruction register and prefetch buffer between instruction memory/fetch and the control FSM.
- Accepts fetched instruction words over a valid/ready handshake and buffers up to DEPTH of them.
- Presents the oldest word split into opcode and operand fields, and supports a single-cycle flush for branches and jumps.
- Replaces the single-entry, always-loading instruction register with a stallable, flushable queue.

Parameters:
- OPCODE_W, 4, opcode field width; occupies the MSBs of the instruction word.
- OPERAND_W, 16, operand field width; occupies the LSBs.
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- Derived, not overridable: IW = OPCODE_W+OPERAND_W; CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  discards all queued entries.
- in_valid  in  1  fetch side presents in_data.
- in_ready  out  1  queue can accept a word this cycle.
- in_data  in  IW  instruction word: {opcode, operand}.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry this cycle.
- opcode  out  OPCODE_W  head entry bits [IW-1:OPERAND_W].
- operand  out  OPERAND_W  head entry bits [OPERAND_W-1:0].
- count  out  CW  number of valid entries, 0..DEPTH.

Behaviour:
- Storage:
  - Circular buffer of DEPTH registers of IW bits.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - A count register tracks occupancy.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Output signals:
  - in_ready = (count != DEPTH). It is registered-state-only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - opcode/operand are decoded combinationally from entry[rd_ptr] when out_valid=1. They are forced to all-zero (NOP) when out_valid=0.
- Latency:
  - A word pushed in cycle N is visible at the outputs with out_valid=1 in cycle N+1 if the queue was empty.
  - There is no bypass path from in_data to the outputs.
- Ordering: strict FIFO. Data must never be duplicated, lost, or reordered except by flush or reset.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged, and both pointers advance.
- Full (count=DEPTH):
  - in_ready=0 and in_valid is ignored.
  - A pop in the full cycle does not enable a same-cycle push; in_ready rises the following cycle.
- Empty (count=0):
  - out_valid=0 and out_ready is ignored.
  - A push in the empty cycle is not poppable that cycle.
- Flush:
  - On the next edge, count=0 and wr_ptr=rd_ptr=0.
  - Flush has priority: a same-cycle push and pop are both discarded.
  - The cycle after flush shows out_valid=0 and in_ready=1.
  - Entry contents need not be cleared.
- Reset (rst_n=0 at an edge):
  - Identical to flush, including when asserted mid-operation.
  - Reset values: count=0, out_valid=0, in_ready=1, opcode=0, operand=0.
  - Reset takes priority over flush and over all handshakes.
- Width rules:
  - in_data is split exactly at bit OPERAND_W. No sign extension or arithmetic on the fields.
  - count never exceeds DEPTH and never underflows.

Test Plan:
- Reset then single word: push in_data=20'hA1234 with out_ready=0. Next cycle out_valid=1, opcode=4'hA, operand=16'h1234, count=1. Pop, then out_valid=0 and opcode/operand=0.
- Fill to full: push 20'h10001..20'h40004 with out_ready=0. Then count=4 and in_ready=0. A 5th word 20'h50005 held on in_valid is not accepted. Drain yields 1,2,3,4 in order, and the 5th is accepted only after in_ready returns to 1.
- Streaming with pointer wrap: hold in_valid=out_ready=1 for 12 words 20'h00000..20'h0000B after one priming push. count stays at 1, and outputs follow in order across the wrap.
- Flush mid-stream: with count=3, assert flush together with in_valid=1 and out_ready=1. Next cycle count=0, out_valid=0, and no word was consumed. A subsequent push of 20'hF00FF appears as the head.
- Reset mid-operation: with count=2, drive rst_n=0 for one edge with in_valid=1. Afterwards count=0, outputs are 0 and in_ready=1. The first post-reset push is the head.
- Full with pop only: at count=4, pop with in_valid=1. The same cycle does not accept the input and count becomes 3. The next cycle accepts it and count returns to 4.
